mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one read port of the instruction/data ROM between the fetch unit (IF) and the load/store unit (LS).
- Arbitrates requests, issues word-aligned reads, and tracks in-flight reads in an owner/address FIFO.
- Routes in-order memory responses back to the owning requester with the original address echoed.
- Sits between the core front-end/LSU and the ROM/memory port; replaces the direct per-unit ROM ports.

Parameters:
- DEPTH, 4, max outstanding reads (owner/address FIFO entries); power of two, 2..16.
- STARVE_LIMIT, 4, consecutive IF-blocked cycles before IF is forced priority; 1..15.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- if_req  input  1  fetch read request; held with if_addr until if_gnt
- if_addr  input  32  fetch byte address
- if_gnt  output  1  combinational grant; request issued this cycle
- if_rvalid  output  1  fetch response valid, one-cycle pulse
- if_rdata  output  32  fetch response data
- if_raddr  output  32  original fetch address of this response
- ls_req  input  1  load request; held with ls_addr until ls_gnt
- ls_addr  input  32  load byte address
- ls_gnt  output  1  combinational grant
- ls_rvalid  output  1  load response valid, one-cycle pulse
- ls_rdata  output  32  load response data
- ls_raddr  output  32  original load address
- mem_en  output  1  issue read this cycle
- mem_addr  output  32  {sel_addr[31:2],2'b00}
- mem_ready  input  1  memory accepts a read this cycle
- mem_rvalid  input  1  in-order read data valid
- mem_rdata  input  32  read data
- err_spurious  output  1  sticky: mem_rvalid seen with FIFO empty

Behaviour:
- Reset (rst_n low at clk edge): FIFO empty, pointers/count 0, starve counter 0, RR pointer to IF, all rvalid 0, all rdata/raddr 0, err_spurious 0. Reset mid-transaction discards in-flight entries. Responses arriving after reset with the FIFO empty set err_spurious.
- can_issue = mem_ready & (count < DEPTH | mem_rvalid). A same-cycle pop frees a slot.
- Fixed priority: LS over IF, except when starve_cnt == STARVE_LIMIT, then IF wins.
- Only one grant per cycle. A grant is asserted only if can_issue. mem_en = if_gnt | ls_gnt.
- mem_addr selects the granted address. When mem_en is 0, mem_addr = 0.
- Starve counter:
  - Increments when if_req & ~if_gnt & can_issue, saturating at STARVE_LIMIT.
  - Clears on if_gnt or ~if_req.
  - Holds when ~can_issue; stalls are not charged to LS.
- FIFO push on grant: {owner, full 32-bit original address}.
- FIFO pop on mem_rvalid with count > 0. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Response latency is 1 cycle: at the clk edge after mem_rvalid, the owner's rvalid goes high for one cycle.
  - rdata = mem_rdata and raddr = popped address.
  - The non-owner's rvalid is 0.
  - rdata/raddr hold their last values when rvalid is low.
- mem_rvalid with count == 0: no pop, no rvalid, err_spurious set until reset.
- Requesters must keep req/addr stable until granted. A request dropped before grant is simply not issued.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin replaces LS-priority.
  - On a conflict, the requester not granted last wins.
  - The last-granted pointer updates on every grant.
  - The starve counter and STARVE_LIMIT are unused; the counter is held at 0.
- Undefined: fixed LS priority with starvation override as above.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with if_req=1 and mem_rvalid=1 -> no grants; all rvalid, err_spurious, mem_en = 0; rdata/raddr = 0.
- IF stream: if_addr 0x00,0x04,0x08 on consecutive cycles, mem_ready=1, memory returns 1 cycle after issue -> if_gnt each cycle, mem_addr 0x00/0x04/0x08, if_rvalid pulses in order with matching if_raddr. Also if_addr=0x06 -> mem_addr=0x04, if_raddr=0x06.
- Conflict/starvation (STARVE_LIMIT=4): if_req and ls_req both held, each re-requesting after grant -> ls_gnt 4 cycles, then if_gnt on 5th, then LS resumes; starve counter returns to 0.
- Backpressure (DEPTH=2): issue 2 reads with no mem_rvalid -> 3rd request not granted; next cycle mem_rvalid=1 -> same-cycle grant, count stays 2. Also mem_ready=0 -> no grant, starve counter unchanged.
- Routing/spurious: issue LS@0x40 then IF@0x44, return 0xAAAA then 0xBBBB -> ls_rvalid with ls_rdata=0xAAAA, ls_raddr=0x40; then if_rvalid with if_rdata=0xBBBB, if_raddr=0x44. An extra mem_rvalid -> err_spurious=1, no rvalid.
- ARB_RR_EN defined: both requesters held for 6 cycles -> grants alternate LS,IF,LS,IF,LS,IF starting LS after reset (pointer at IF means LS wins first).

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the fetch unit, the load/store unit, the shared ROM read port and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic [31:0] if_raddr;

  logic        ls_req;
  logic [31:0] ls_addr;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic [31:0] ls_raddr;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        err_spurious;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_raddr,
    output ls_gnt, ls_rvalid, ls_rdata, ls_raddr,
    output mem_en, mem_addr, err_spurious
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_raddr,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_raddr,
    input  mem_en, mem_addr, err_spurious
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one ROM read port between fetch (IF) and load/store (LS), routing in-order responses back to the owner.
// Optional macro ARB_RR_EN: round-robin arbitration instead of LS priority with IF starvation override.
module mem_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  owner_e        r_owner [DEPTH];
  logic [31:0]   r_addr  [DEPTH];

  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_if_raddr;
  logic        r_ls_rvalid;
  logic [31:0] r_ls_rdata;
  logic [31:0] r_ls_raddr;
  logic        r_err_spurious;

  logic        w_can_issue;
  logic        w_if_prio;
  logic        w_if_gnt;
  logic        w_ls_gnt;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_sel_addr;
  owner_e      w_pop_owner;
  logic [31:0] w_pop_addr;

  // A response retiring this cycle frees its slot for a new read in the same cycle.
  assign w_can_issue = rst_n & bus.mem_ready &
                       ((r_count < CW'(DEPTH)) | bus.mem_rvalid);
  assign w_pop       = bus.mem_rvalid & (r_count != '0);
  assign w_push      = w_if_gnt | w_ls_gnt;
  assign w_pop_owner = r_owner[r_rd_ptr];
  assign w_pop_addr  = r_addr[r_rd_ptr];

`ifdef ARB_RR_EN
  logic r_last_ls;

  assign w_if_prio = r_last_ls;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_ls <= 1'b0;
    end else if (w_ls_gnt) begin
      r_last_ls <= 1'b1;
    end else if (w_if_gnt) begin
      r_last_ls <= 1'b0;
    end
  end
`else
  logic [3:0] r_starve;

  assign w_if_prio = (r_starve == 4'(STARVE_LIMIT));

  // Stalled cycles (no issue possible) are not charged against LS.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_if_gnt || !bus.if_req) begin
      r_starve <= '0;
    end else if (w_can_issue && (r_starve != 4'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ls_gnt   = 1'b0;
    w_if_gnt   = 1'b0;
    w_sel_addr = bus.if_addr;
    if (w_can_issue) begin
      w_ls_gnt = bus.ls_req & ~(bus.if_req & w_if_prio);
      w_if_gnt = bus.if_req & ~w_ls_gnt;
    end
    if (w_ls_gnt) begin
      w_sel_addr = bus.ls_addr;
    end
  end

  assign bus.if_gnt   = w_if_gnt;
  assign bus.ls_gnt   = w_ls_gnt;
  assign bus.mem_en   = w_push;
  assign bus.mem_addr = w_push ? {w_sel_addr[31:2], 2'b00} : 32'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; only the pointers and count qualify its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_owner[r_wr_ptr] <= w_ls_gnt ? OWN_LS : OWN_IF;
      r_addr[r_wr_ptr]  <= w_ls_gnt ? bus.ls_addr : bus.if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_rvalid    <= 1'b0;
      r_if_rdata     <= '0;
      r_if_raddr     <= '0;
      r_ls_rvalid    <= 1'b0;
      r_ls_rdata     <= '0;
      r_ls_raddr     <= '0;
      r_err_spurious <= 1'b0;
    end else begin
      r_if_rvalid <= w_pop & (w_pop_owner == OWN_IF);
      r_ls_rvalid <= w_pop & (w_pop_owner == OWN_LS);
      if (w_pop && (w_pop_owner == OWN_IF)) begin
        r_if_rdata <= bus.mem_rdata;
        r_if_raddr <= w_pop_addr;
      end
      if (w_pop && (w_pop_owner == OWN_LS)) begin
        r_ls_rdata <= bus.mem_rdata;
        r_ls_raddr <= w_pop_addr;
      end
      if (bus.mem_rvalid && (r_count == '0)) begin
        r_err_spurious <= 1'b1;
      end
    end
  end

  assign bus.if_rvalid    = r_if_rvalid;
  assign bus.if_rdata     = r_if_rdata;
  assign bus.if_raddr     = r_if_raddr;
  assign bus.ls_rvalid    = r_ls_rvalid;
  assign bus.ls_rdata     = r_ls_rdata;
  assign bus.ls_raddr     = r_ls_raddr;
  assign bus.err_spurious = r_err_spurious;

endmodule
